// File: rtl/pipeline_ctrl_pkg.sv
// Shared CPU package: pipeline-control FSM states, multiply latency, counter width,
// and the opcode/func7 constants used to recognise a multiply.
package pipeline_ctrl_pkg;

  localparam int unsigned MUL_LAT_DEF = 2;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned REG_W       = 5;
  localparam int unsigned OPC_W       = 7;

  localparam logic [OPC_W-1:0] OPC_RTYPE    = 7'b0110011;
  localparam logic [OPC_W-1:0] FUNC7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic mul_start;
    logic mul_abort;
  } ctrl_t;

  localparam ctrl_t CTRL_OFF   = '{default: 1'b0};
  localparam ctrl_t CTRL_NORM  = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
                                   memwb_en: 1'b1, default: 1'b0};
  // Multiply stall: freeze front end, bubble into MEM, let older instructions drain.
  localparam ctrl_t CTRL_STALL = '{exmem_en: 1'b1, memwb_en: 1'b1, exmem_flush: 1'b1,
                                   default: 1'b0};
  localparam ctrl_t CTRL_LU    = '{idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
                                   idex_flush: 1'b1, default: 1'b0};

  // R-type with func7[0] set is an M-extension multiply.
  function automatic logic is_mul(input logic [OPC_W-1:0] opcode,
                                  input logic [OPC_W-1:0] func7);
    return (opcode == OPC_RTYPE) && ((func7 & FUNC7_MULDIV) != '0);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard detect: EX load writes a non-zero register read by the ID instruction.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_waddr,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  output logic             hazard
);

  always_comb begin
    hazard = ex_mem_read && (ex_waddr != '0) &&
             ((ex_waddr == id_rs1) || (ex_waddr == id_rs2));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: redirect flush, multi-cycle multiply stall, load-use stall.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             enable,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_waddr,
  input  logic             ex_is_mul,
  input  logic             mem_redirect,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             mul_start,
  output logic             mul_abort,
  output logic             mul_busy
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);

  state_e           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  ctrl_t            ctrl;
  logic             hazard;

  load_use_detect u_load_use_detect (
    .ex_mem_read (ex_mem_read),
    .ex_waddr    (ex_waddr),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .hazard      (hazard)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Outputs are combinational; reset forces IDLE behaviour so no pulse escapes during reset.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ctrl       = CTRL_OFF;
    if (!arst_n) begin
      if (enable) ctrl = CTRL_NORM;
    end else if (enable) begin
      if (mem_redirect) begin
        ctrl             = CTRL_NORM;
        ctrl.ifid_flush  = 1'b1;
        ctrl.idex_flush  = 1'b1;
        ctrl.exmem_flush = 1'b1;
        ctrl.mul_abort   = (state != ST_IDLE);
        state_next       = ST_IDLE;
        cnt_next         = '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (ex_is_mul) begin
              ctrl           = CTRL_STALL;
              ctrl.mul_start = 1'b1;
              cnt_next       = CNT_INIT;
              state_next     = (MUL_LAT == 1) ? ST_DONE : ST_BUSY;
            end else if (hazard) begin
              ctrl = CTRL_LU;
            end else begin
              ctrl = CTRL_NORM;
            end
          end
          ST_BUSY: begin
            ctrl     = CTRL_STALL;
            cnt_next = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state_next = ST_DONE;
          end
          ST_DONE: begin
            // ex_is_mul still reflects the finished multiply; never restart it here.
            ctrl       = CTRL_NORM;
            state_next = ST_IDLE;
          end
          default: state_next = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    pc_en       = ctrl.pc_en;
    ifid_en     = ctrl.ifid_en;
    idex_en     = ctrl.idex_en;
    exmem_en    = ctrl.exmem_en;
    memwb_en    = ctrl.memwb_en;
    ifid_flush  = ctrl.ifid_flush;
    idex_flush  = ctrl.idex_flush;
    exmem_flush = ctrl.exmem_flush;
    mul_start   = ctrl.mul_start;
    mul_abort   = ctrl.mul_abort;
    mul_busy    = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: four instances at MUL_LAT = 2, 1, 4, 15 share stimulus.
module tb_pipeline_ctrl;

  // Observation order: pc,ifid,idex,exmem,memwb, ifid_fl,idex_fl,exmem_fl, start,abort,busy
  localparam logic [10:0] V_NORM     = 11'b11111_000_00_0;
  localparam logic [10:0] V_LU       = 11'b00111_010_00_0;
  localparam logic [10:0] V_START    = 11'b00011_001_10_0;
  localparam logic [10:0] V_BUSY     = 11'b00011_001_00_1;
  localparam logic [10:0] V_DONE     = 11'b11111_000_00_1;
  localparam logic [10:0] V_RD_ABORT = 11'b11111_111_01_1;
  localparam logic [10:0] V_RD_IDLE  = 11'b11111_111_00_0;
  localparam logic [10:0] V_DIS_IDLE = 11'b00000_000_00_0;
  localparam logic [10:0] V_DIS_BUSY = 11'b00000_000_00_1;

  logic       clk = 1'b0;
  logic       arst_n, enable, ex_mem_read, ex_is_mul, mem_redirect;
  logic [4:0] id_rs1, id_rs2, ex_waddr;
  logic [3:0] pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic [3:0] ifid_flush, idex_flush, exmem_flush, mul_start, mul_abort, mul_busy;

  int vectors, miscompares, starts, stalls;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    pipeline_ctrl #(.MUL_LAT(g == 0 ? 2 : g == 1 ? 1 : g == 2 ? 4 : 15)) u_dut (
      .clk          (clk),
      .arst_n       (arst_n),
      .enable       (enable),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .ex_mem_read  (ex_mem_read),
      .ex_waddr     (ex_waddr),
      .ex_is_mul    (ex_is_mul),
      .mem_redirect (mem_redirect),
      .pc_en        (pc_en[g]),
      .ifid_en      (ifid_en[g]),
      .idex_en      (idex_en[g]),
      .exmem_en     (exmem_en[g]),
      .memwb_en     (memwb_en[g]),
      .ifid_flush   (ifid_flush[g]),
      .idex_flush   (idex_flush[g]),
      .exmem_flush  (exmem_flush[g]),
      .mul_start    (mul_start[g]),
      .mul_abort    (mul_abort[g]),
      .mul_busy     (mul_busy[g])
    );
  end

  function automatic logic [10:0] obs(input int g);
    return {pc_en[g], ifid_en[g], idex_en[g], exmem_en[g], memwb_en[g],
            ifid_flush[g], idex_flush[g], exmem_flush[g],
            mul_start[g], mul_abort[g], mul_busy[g]};
  endfunction

  task automatic chk(input int g, input logic [10:0] exp, input string tag);
    logic [10:0] o;
    o = obs(g);
    vectors++;
    assert (o === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d observed=%b expected=%b", tag, g, o, exp);
    end
  endtask

  task automatic chk_int(input int o, input int exp, input string tag);
    vectors++;
    assert (o === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    enable = 1'b1; ex_mem_read = 1'b0; ex_is_mul = 1'b0; mem_redirect = 1'b0;
    id_rs1 = '0; id_rs2 = '0; ex_waddr = '0;
  endtask

  task automatic do_reset();
    nxt(); arst_n = 1'b0; clear_inputs();
    nxt(); arst_n = 1'b1;
  endtask

  initial begin
    vectors = 0; miscompares = 0; starts = 0; stalls = 0;
    arst_n = 1'b0; clear_inputs();
    #1;
    for (int g = 0; g < 4; g++) chk(g, V_NORM, "reset");
    ex_is_mul = 1'b1; #1;
    chk(2, V_NORM, "reset_no_start");
    ex_is_mul = 1'b0;
    nxt(); arst_n = 1'b1;

    // lw x5 then add x6,x5,x1: one-cycle stall, then a bubble in EX releases it
    nxt(); ex_mem_read = 1'b1; ex_waddr = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd1; #1;
    chk(0, V_LU, "lu_stall");
    nxt(); ex_mem_read = 1'b0; ex_waddr = 5'd0; #1;
    chk(0, V_NORM, "lu_release");
    nxt(); ex_mem_read = 1'b1; ex_waddr = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; #1;
    chk(0, V_LU, "lu_rs2");
    nxt(); ex_waddr = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; #1;
    chk(0, V_NORM, "lu_x0");
    nxt(); ex_waddr = 5'd5; id_rs1 = 5'd5; mem_redirect = 1'b1; #1;
    chk(0, V_RD_IDLE, "lu_redirect");
    nxt(); mem_redirect = 1'b0; enable = 1'b0; #1;
    chk(0, V_DIS_IDLE, "disabled_idle");
    nxt(); clear_inputs(); #1;
    chk(0, V_NORM, "normal");

    // MUL_LAT=2
    nxt(); ex_is_mul = 1'b1; #1; chk(0, V_START, "m2_start");
    nxt(); #1; chk(0, V_BUSY, "m2_busy");
    nxt(); #1; chk(0, V_DONE, "m2_done");
    nxt(); ex_is_mul = 1'b0; #1; chk(0, V_NORM, "m2_idle");

    // MUL_LAT=1 back-to-back
    do_reset(); starts = 0;
    for (int k = 0; k < 4; k++) begin
      nxt(); ex_is_mul = 1'b1; #1;
      chk(1, (k % 2 == 0) ? V_START : V_DONE, "m1_b2b");
      starts += int'(mul_start[1]);
    end
    nxt(); ex_is_mul = 1'b0; #1; chk(1, V_NORM, "m1_idle");
    chk_int(starts, 2, "m1_starts");

    // MUL_LAT=15 back-to-back
    do_reset(); starts = 0;
    for (int k = 0; k < 32; k++) begin
      nxt(); ex_is_mul = 1'b1; #1;
      chk(3, (k % 16 == 0) ? V_START : (k % 16 == 15) ? V_DONE : V_BUSY, "m15_b2b");
      starts += int'(mul_start[3]);
    end
    nxt(); ex_is_mul = 1'b0; #1; chk(3, V_NORM, "m15_idle");
    chk_int(starts, 2, "m15_starts");

    // MUL_LAT=4, redirect in second BUSY cycle
    do_reset();
    nxt(); ex_is_mul = 1'b1; #1; chk(2, V_START, "rd_start");
    nxt(); #1; chk(2, V_BUSY, "rd_busy1");
    nxt(); mem_redirect = 1'b1; #1; chk(2, V_RD_ABORT, "rd_abort");
    nxt(); mem_redirect = 1'b0; ex_is_mul = 1'b0; #1; chk(2, V_NORM, "rd_idle");

    // MUL_LAT=4, enable low 3 cycles mid-BUSY
    do_reset(); stalls = 0;
    nxt(); ex_is_mul = 1'b1; #1; chk(2, V_START, "en_start");
    stalls += int'(enable & ~pc_en[2]);
    nxt(); #1; chk(2, V_BUSY, "en_busy_a");
    stalls += int'(enable & ~pc_en[2]);
    for (int k = 0; k < 3; k++) begin
      nxt(); enable = 1'b0; #1; chk(2, V_DIS_BUSY, "en_frozen");
    end
    nxt(); enable = 1'b1; #1; chk(2, V_BUSY, "en_busy_b");
    stalls += int'(enable & ~pc_en[2]);
    nxt(); #1; chk(2, V_BUSY, "en_busy_c");
    stalls += int'(enable & ~pc_en[2]);
    nxt(); #1; chk(2, V_DONE, "en_done");
    stalls += int'(enable & ~pc_en[2]);
    nxt(); ex_is_mul = 1'b0; #1; chk(2, V_NORM, "en_idle");
    chk_int(stalls, 4, "en_stall_total");

    // MUL_LAT=4, async reset mid-BUSY
    do_reset();
    nxt(); ex_is_mul = 1'b1; #1; chk(2, V_START, "ar_start");
    nxt(); #1; chk(2, V_BUSY, "ar_busy");
    #2; arst_n = 1'b0; #1; chk(2, V_NORM, "ar_idle");
    nxt(); arst_n = 1'b1; ex_is_mul = 1'b0; #1; chk(2, V_NORM, "ar_after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 2: multiply-unit latency in cycles, legal range 1..15.
REQ-002 SHALL have clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have arst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have enable  input  1  global run enable, same meaning as the CPU enable.
REQ-005 SHALL have id_rs1, id_rs2  input  5 each  source register addresses of the instruction in ID.
REQ-006 SHALL have ex_mem_read  input  1  EX instruction is a load.
REQ-007 SHALL have ex_waddr  input  5  destination register of the EX instruction.
REQ-008 SHALL have ex_is_mul  input  1  EX instruction is a multiply (R-type, func7[0]=1).
REQ-009 SHALL have mem_redirect  input  1  taken branch or jump in MEM: (MEM_branch & MEM_zero_flag) | MEM_jump.
REQ-010 SHALL have pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1 each  pipeline register enables.
REQ-011 SHALL have ifid_flush, idex_flush, exmem_flush  output  1 each  load a bubble (all controls 0) into that register.
REQ-012 SHALL have mul_start, mul_abort  output  1 each  single-cycle pulses to the multiply unit.
REQ-013 SHALL have mul_busy  output  1  high in BUSY and DONE states.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE plus a 4-bit down-counter cnt.
REQ-015 SHALL, when enable=0, drive all enables, flushes and pulses to 0 and hold state and cnt.
REQ-016 Priority with enable=1: redirect > multiply > load-use > normal flow.
REQ-017 Redirect: mem_redirect=1 SHALL assert ifid_flush, idex_flush, exmem_flush, all enables 1, and force next state IDLE in that cycle.
REQ-018 Redirect while in BUSY or DONE SHALL pulse mul_abort for that cycle; mul_start SHALL be 0 in any redirect cycle.
REQ-019 Multiply start: in IDLE with ex_is_mul=1, mul_start=1; next state BUSY with cnt=MUL_LAT-1, or DONE if MUL_LAT=1.
REQ-020 While stalled for a multiply (IDLE-start cycle and BUSY), pc_en=ifid_en=idex_en=0, exmem_flush=1, exmem_en=1, memwb_en=1, so older instructions drain.
REQ-021 BUSY SHALL decrement cnt each enabled cycle and go to DONE when cnt reaches 1 (cnt=1 -> DONE).
REQ-022 DONE SHALL assert all enables, with no flush, and go to IDLE next; ex_is_mul is ignored in DONE, so the same multiply never restarts.
REQ-023 A multiply SHALL occupy EX for exactly MUL_LAT+1 enabled cycles (MUL_LAT stall cycles); back-to-back multiplies SHALL each take MUL_LAT+1 cycles.
REQ-024 Load-use condition: IDLE, ex_mem_read=1, ex_waddr!=0, and ex_waddr equals id_rs1 or id_rs2.
REQ-025 On load-use, the block SHALL drive pc_en=ifid_en=0, idex_flush=1, idex_en=exmem_en=memwb_en=1 for exactly one cycle.
REQ-026 Normal flow SHALL drive all enables 1, all flushes 0 and no pulses.
REQ-027 Outputs SHALL be combinational from state, cnt and inputs; only state and cnt are registered.

Reset
REQ-028 arst_n=0 SHALL asynchronously set state=IDLE and cnt=0, including mid-multiply, with no mul_abort pulse.
REQ-029 While in reset, mul_busy=0, mul_start=0 and mul_abort=0; enables follow REQ-015/REQ-026 evaluated in IDLE.

Structure
REQ-030 The state enum, MUL_LAT default, counter width (4) and the opcode/func7 constants used to build ex_is_mul SHALL live in the shared CPU package.
REQ-031 SHALL contain one sub-module, load_use_detect (combinational, implements REQ-024).

Verification
REQ-032 Load x5, then `add x6,x5,x1` -> exactly one cycle with pc_en=0 and idex_flush=1; x6 gets the correct sum.
REQ-033 MUL_LAT=2, multiply in EX -> mul_start pulses once; pc_en=0 for 2 cycles; mul_busy high 2 cycles; DONE, then IDLE.
REQ-034 MUL_LAT=1 and MUL_LAT=15, back-to-back multiplies -> per-multiply occupancy of 2 and 16 cycles respectively; exactly two mul_start pulses.
REQ-035 mem_redirect=1 in the second BUSY cycle (MUL_LAT=4) -> mul_abort pulse; all three flushes asserted; state IDLE next cycle; no mul_start in that cycle.
REQ-036 Load-use with ex_waddr=0 -> no stall; load-use coincident with mem_redirect -> flushes only, pc_en=1.
REQ-037 enable=0 held 3 cycles mid-BUSY -> cnt frozen, stall total still MUL_LAT; arst_n low mid-BUSY -> IDLE immediately and mul_busy=0.
